// File: rtl/gray2bin_sched.sv
// gray2bin_sched: round-robin arbiter in front of a single bit-serial
// Gray-to-binary decoder. One requester is granted per conversion, the word
// is decoded MSB-first at one bit per clock, and the result is presented
// together with the winning requester's index on a valid/ready port.
module gray2bin_sched #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_gray,
  output logic [NREQ-1:0]         req_ready,
  output logic                    res_valid,
  output logic [WIDTH-1:0]        res_bin,
  output logic [IDW-1:0]          res_id,
  input  logic                    res_ready,
  output logic                    busy
);

  localparam int KW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   id_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] b_q;

  logic             found_d;
  logic [IDW-1:0]   win_d;
  logic [WIDTH-1:0] win_gray_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] b_upper;
  logic [IDW-1:0]   rr_ptr_d;
  int               arb_idx;

  // Round-robin search: first asserted req_valid at or above rr_ptr, wrapping.
  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    arb_idx = 0;
    for (int off = 0; off < NREQ; off++) begin
      arb_idx = int'(rr_ptr_q) + off;
      if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
      if (!found_d && req_valid[arb_idx]) begin
        found_d = 1'b1;
        win_d   = IDW'(arb_idx);
      end
    end
  end

  assign win_gray_d = req_gray[win_d*WIDTH +: WIDTH];

  // Grant strobe is only offered from IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && found_d && !rst) req_ready[win_d] = 1'b1;
  end

  // Bit above the current index; zero above the MSB so b[MSB] = g[MSB].
  assign b_upper = {1'b0, b_q[WIDTH-1:1]};

  // One decode step: only bit k of the binary register changes this cycle.
  always_comb begin
    b_d = b_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (k_q == KW'(i)) b_d[i] = g_q[i] ^ b_upper[i];
    end
  end

  // Pointer moves just past the requester that was served, wrapping at NREQ.
  assign rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

  // Scheduler FSM: accept in IDLE, decode WIDTH bits in CONV, hold result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      k_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            g_q     <= win_gray_d;
            id_q    <= win_d;
            b_q     <= '0;
            k_q     <= KW'(WIDTH - 1);
            state_q <= CONV;
          end
        end
        CONV: begin
          b_q <= b_d;
          if (k_q == '0) begin
            state_q <= DONE;
          end else begin
            k_q <= k_q - 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = (state_q == DONE);
  assign res_bin   = b_q;
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule
